lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Multicycle load/store controller for the RV32I core. It accepts one decoded load/store at a time from the execute stage and issues a single word-aligned data-memory access with byte masks and lane-shifted write data. It waits for the memory response, sign- or zero-extends load data, and returns the result to writeback. Misaligned or illegal-funct3 accesses are rejected without touching memory.

Parameters:
TIMEOUT_CYCLES, 256, watchdog limit on dmem_resp wait (used only with LSU_TIMEOUT_EN); range 2..65535

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request (high only in IDLE)
req_opcode  in  7  rv32i_opcode; only op_b_load/op_b_store legal
req_funct3  in  3  load_f3_t / store_f3_t
req_addr  in  32  effective address (rs1+imm, computed upstream)
req_wdata  in  32  rs2 value, store data, low-aligned
req_rd  in  5  destination register for loads
dmem_addr  out  32  word address {addr[31:2],2'b00}
dmem_rmask  out  4  read byte enables
dmem_wmask  out  4  write byte enables
dmem_wdata  out  32  lane-shifted store data
dmem_rdata  in  32  read data, valid with dmem_resp
dmem_resp  in  1  memory done, single-cycle pulse
resp_valid  out  1  result available
resp_ready  in  1  writeback accepts result
resp_rd  out  5  rd for loads; 0 for stores and errors
resp_data  out  32  extended load data; 0 for stores and errors
resp_err  out  2  0 ok, 1 misaligned, 2 illegal (op/funct3), 3 timeout

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset (rst=1 at a clk edge) from any state goes to IDLE. All outputs read 0 except req_ready=1. Any in-flight access is abandoned and a later dmem_resp is ignored.
- IDLE: req_ready=1. On req_valid, latch opcode, funct3, addr, wdata and rd, then classify:
  - illegal (opcode not load/store; load funct3 in {3,6,7}; store funct3 >= 3) -> RESP with err=2.
  - misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> RESP with err=1.
  - otherwise -> WAIT. Illegal takes priority over misaligned.
- WAIT: masks, dmem_addr and dmem_wdata are registered and held constant every WAIT cycle, and are 0 in all other states. Earliest dmem_resp is the first WAIT cycle, giving 2-cycle minimum accept-to-resp_valid latency.
- Mask rules, with o = addr[1:0]:
  - byte: 4'b0001<<o
  - half: 4'b0011<<o
  - word: 4'b1111
  - Loads drive rmask and keep wmask=0. Stores do the reverse.
  - dmem_wdata = req_wdata << (8*o).
- On dmem_resp in WAIT: capture data, go to RESP with err=0. For loads, shift dmem_rdata right by 8*o, then extend by funct3:
  - lb, lh: sign-extend
  - lbu, lhu: zero-extend
  - lw: pass through
- RESP: resp_valid=1. resp_* are held stable until resp_ready. resp_valid & resp_ready -> IDLE. A new request is accepted no earlier than the next cycle (no bypass).
- dmem_resp outside WAIT: ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a 16-bit counter clears on WAIT entry and increments each WAIT cycle without dmem_resp. When the count reaches TIMEOUT_CYCLES, masks drop and the FSM goes to RESP with err=3. If dmem_resp coincides with the timeout cycle, dmem_resp wins (err=0).
- Undefined: no counter; WAIT lasts indefinitely; err=3 is never produced.

Decomposition:
- Add to rv32i_types:
  - lsu_state_t enum (IDLE/WAIT/RESP)
  - lsu_err_t enum (OK/MISALIGN/ILLEGAL/TIMEOUT)
  - functions lsu_mask(funct3, offset) and lsu_extend(funct3, offset, rdata)
- Reuse rv32i_opcode, load_f3_t and store_f3_t unchanged.
- One sub-module: lsu_align, purely combinational. It produces mask, shifted wdata, extended rdata and the misalign/illegal flags. lsu_ctrl holds the FSM and registers.

Test Plan:
- sw, addr=0x1000, wdata=0xDEADBEEF, dmem_resp on first WAIT cycle -> dmem_addr=0x1000, wmask=4'hF, wdata=0xDEADBEEF, rmask=0. resp_valid 2 cycles after accept, err=0, rd=0.
- lb, addr=0x2003, rdata=0x80FF_FF7F, rd=5 -> rmask=4'b1000, resp_data=0xFFFFFF80, rd=5. Repeat with lbu -> 0x00000080.
- sh, addr=0x3002, wdata=0x0000ABCD -> wmask=4'b1100, dmem_wdata=0xABCD0000. lhu at 0x3002 with rdata=0xABCD1234 -> 0x0000ABCD.
- lw, addr=0x4001 -> no mask ever asserted, err=1. load funct3=3'b110 -> err=2. resp_ready held low 3 cycles -> resp_* stable, req_ready=0 throughout.
- Load accepted, rst pulsed in WAIT, then dmem_resp arrives the cycle after -> outputs cleared, req_ready=1, no resp_valid.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no dmem_resp -> masks held exactly 4 WAIT cycles, then resp_valid with err=3. Rerun with dmem_resp on the 4th cycle -> err=0.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared RV32I types plus load/store helpers used by lsu_ctrl and lsu_align.
package lsu_ctrl_pkg;

  typedef enum logic [6:0] {
    op_b_lui   = 7'b0110111,
    op_b_auipc = 7'b0010111,
    op_b_jal   = 7'b1101111,
    op_b_jalr  = 7'b1100111,
    op_b_br    = 7'b1100011,
    op_b_load  = 7'b0000011,
    op_b_store = 7'b0100011,
    op_b_imm   = 7'b0010011,
    op_b_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_f3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_f3_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} lsu_state_t;
  typedef enum logic [1:0] {OK, MISALIGN, ILLEGAL, TIMEOUT} lsu_err_t;

  // Byte enables for the access size encoded in funct3 (same codes for loads and stores).
  function automatic logic [3:0] lsu_mask(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      lb, lbu: return 4'b0001 << offset;
      lh, lhu: return 4'b0011 << offset;
      lw:      return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lsu_extend(input logic [2:0] funct3, input logic [1:0] offset,
                                             input logic [31:0] rdata);
    logic [31:0] s;
    s = rdata >> {offset, 3'b000};
    case (funct3)
      lb:      return {{24{s[7]}}, s[7:0]};
      lh:      return {{16{s[15]}}, s[15:0]};
      lw:      return s;
      lbu:     return {24'd0, s[7:0]};
      lhu:     return {16'd0, s[15:0]};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request, data-memory and response signals of the LSU; slave = lsu_ctrl, master = its environment.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;

  modport slave (
    input  req_valid, req_opcode, req_funct3, req_addr, req_wdata, req_rd,
    input  dmem_rdata, dmem_resp, resp_ready,
    output req_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output resp_valid, resp_rd, resp_data, resp_err
  );

  modport master (
    output req_valid, req_opcode, req_funct3, req_addr, req_wdata, req_rd,
    output dmem_rdata, dmem_resp, resp_ready,
    input  req_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  resp_valid, resp_rd, resp_data, resp_err
  );
endinterface

// File: rtl/lsu_ctrl_align.sv
// lsu_align: combinational classification, byte-lane masking/shifting and load extension.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        is_load,
  output logic [3:0]  mask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        illegal,
  output logic        misalign
);
  logic is_store;

  always_comb begin
    is_load   = (opcode == op_b_load);
    is_store  = (opcode == op_b_store);
    illegal   = !(is_load || is_store) ||
                (is_load && (funct3 inside {3'd3, 3'd6, 3'd7})) ||
                (is_store && (funct3 >= 3'd3));
    misalign  = ((funct3[1:0] == 2'b01) && offset[0]) ||
                ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    mask      = lsu_mask(funct3, offset);
    wdata_sh  = wdata << {offset, 3'b000};
    rdata_ext = lsu_extend(funct3, offset, rdata);
  end
endmodule

// File: rtl/lsu_ctrl.sv
// Multicycle RV32I load/store controller. Optional watchdog on the memory wait: LSU_TIMEOUT_EN.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic       clk,
  input logic       rst,
  lsu_ctrl_if.slave bus
);
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
    $error("lsu_ctrl: TIMEOUT_CYCLES must be within 2..65535");
  end

  lsu_state_t  state_q, state_d;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        is_load_q;
  logic [31:0] dmem_addr_q, dmem_wdata_q;
  logic [3:0]  dmem_rmask_q, dmem_wmask_q;
  logic [31:0] resp_data_q;
  logic [4:0]  resp_rd_q;
  lsu_err_t    resp_err_q;
  logic        tmo_hit;

  logic [2:0]  al_funct3;
  logic [1:0]  al_offset;
  logic        al_is_load, al_illegal, al_misalign;
  logic [3:0]  al_mask;
  logic [31:0] al_wdata, al_rdata;

  // In IDLE the aligner sees the incoming request; afterwards the latched one.
  assign al_funct3 = (state_q == IDLE) ? bus.req_funct3 : f3_q;
  assign al_offset = (state_q == IDLE) ? bus.req_addr[1:0] : off_q;

  lsu_align u_align (
    .opcode    (bus.req_opcode),
    .funct3    (al_funct3),
    .offset    (al_offset),
    .wdata     (bus.req_wdata),
    .rdata     (bus.dmem_rdata),
    .is_load   (al_is_load),
    .mask      (al_mask),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata),
    .illegal   (al_illegal),
    .misalign  (al_misalign)
  );

`ifdef LSU_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != WAIT) tmo_cnt_q <= '0;
    else                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) && !bus.dmem_resp;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = (al_illegal || al_misalign) ? RESP : WAIT;
      WAIT:    if (bus.dmem_resp || tmo_hit) state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers carry no reset; outputs are gated by state instead.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.req_valid) begin
      f3_q         <= bus.req_funct3;
      off_q        <= bus.req_addr[1:0];
      rd_q         <= bus.req_rd;
      is_load_q    <= al_is_load;
      dmem_addr_q  <= {bus.req_addr[31:2], 2'b00};
      dmem_rmask_q <= al_is_load ? al_mask : 4'b0000;
      dmem_wmask_q <= al_is_load ? 4'b0000 : al_mask;
      dmem_wdata_q <= al_is_load ? 32'd0 : al_wdata;
      resp_data_q  <= 32'd0;
      resp_rd_q    <= 5'd0;
      resp_err_q   <= al_illegal ? ILLEGAL : (al_misalign ? MISALIGN : OK);
    end else if (state_q == WAIT) begin
      if (bus.dmem_resp) begin
        resp_err_q  <= OK;
        resp_data_q <= is_load_q ? al_rdata : 32'd0;
        resp_rd_q   <= is_load_q ? rd_q : 5'd0;
      end else if (tmo_hit) begin
        resp_err_q  <= TIMEOUT;
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.dmem_addr  = (state_q == WAIT) ? dmem_addr_q  : 32'd0;
  assign bus.dmem_rmask = (state_q == WAIT) ? dmem_rmask_q : 4'd0;
  assign bus.dmem_wmask = (state_q == WAIT) ? dmem_wmask_q : 4'd0;
  assign bus.dmem_wdata = (state_q == WAIT) ? dmem_wdata_q : 32'd0;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rd    = (state_q == RESP) ? resp_rd_q   : 5'd0;
  assign bus.resp_data  = (state_q == RESP) ? resp_data_q : 32'd0;
  assign bus.resp_err   = (state_q == RESP) ? resp_err_q  : OK;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed table, reset/timeout sequences and randomized traffic vs a reference model.
module tb_lsu_ctrl;
  localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          delay;
    int          hold;
    logic [3:0]  e_rmask;
    logic [3:0]  e_wmask;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic [1:0]  e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  lsu_ctrl_if bus ();

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd,
                              input int delay, input int hold, input logic [3:0] rm, input logic [3:0] wm,
                              input logic [31:0] ewd, input logic [31:0] ed, input logic [4:0] erd,
                              input logic [1:0] eerr);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd;
    v.delay = delay; v.hold = hold; v.e_rmask = rm; v.e_wmask = wm; v.e_wdata = ewd;
    v.e_data = ed; v.e_rd = erd; v.e_err = eerr;
    return v;
  endfunction

  // Reference model: access size, alignment and extension derived arithmetically.
  function automatic vec_t model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input logic [4:0] rd, input int delay, input int hold);
    vec_t   v;
    bit     ld, st, legal;
    int     size, off;
    longint val, span;
    v = mk(op, f3, addr, wdata, rdata, rd, delay, hold, 0, 0, 0, 0, 0, 0);
    ld    = (op == 7'h03);
    st    = (op == 7'h23);
    off   = int'(addr % 4);
    size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : (f3 % 4 == 2) ? 4 : 0;
    legal = (ld && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) || (st && f3 < 3);
    if (!legal) begin
      v.e_err = 2;
    end else if (off % size != 0) begin
      v.e_err = 1;
    end else begin
      val = ((longint'(1) << size) - 1) << off;
      if (ld) v.e_rmask = val[3:0];
      else    v.e_wmask = val[3:0];
      if (st) begin
        val = (longint'(wdata) * (longint'(1) << (8 * off))) % (longint'(1) << 32);
        v.e_wdata = val[31:0];
      end
      if (TMO_EN && delay >= TO) begin
        v.e_err = 3;
      end else if (ld) begin
        span = longint'(1) << (8 * size);
        val  = (longint'(rdata) / (longint'(1) << (8 * off))) % span;
        if (f3 < 4 && size < 4 && val >= span / 2) val = val - span;
        v.e_data = val[31:0];
        v.e_rd   = rd;
      end
    end
    return v;
  endfunction

  task automatic run(input vec_t v);
    bit rej, tmo;
    int waits;
    rej   = (v.e_err == 2'd1) || (v.e_err == 2'd2);
    tmo   = (v.e_err == 2'd3);
    waits = tmo ? TO : v.delay + 1;
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_opcode = v.op;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_rd     = v.rd;
    step();
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    if (!rej) begin
      for (int k = 0; k < waits; k++) begin
        chk("wait_rmask", {28'd0, bus.dmem_rmask}, {28'd0, v.e_rmask});
        chk("wait_wmask", {28'd0, bus.dmem_wmask}, {28'd0, v.e_wmask});
        chk("wait_addr", bus.dmem_addr, v.addr & 32'hFFFF_FFFC);
        if (v.op == 7'h23) chk("wait_wdata", bus.dmem_wdata, v.e_wdata);
        chk("wait_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("wait_req_ready", {31'd0, bus.req_ready}, 32'd0);
        if (!tmo && k == v.delay) begin
          bus.dmem_resp  = 1'b1;
          bus.dmem_rdata = v.rdata;
        end
        step();
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = $urandom;
      end
    end
    for (int h = 0; h <= v.hold; h++) begin
      chk("resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("resp_err", {30'd0, bus.resp_err}, {30'd0, v.e_err});
      chk("resp_data", bus.resp_data, v.e_data);
      chk("resp_rd", {27'd0, bus.resp_rd}, {27'd0, v.e_rd});
      chk("resp_masks", {24'd0, bus.dmem_rmask, bus.dmem_wmask}, 32'd0);
      chk("resp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      bus.dmem_resp = 1'($urandom_range(0, 1));
      if (h == v.hold) bus.resp_ready = 1'b1;
      step();
      bus.dmem_resp = 1'b0;
    end
    bus.resp_ready = 1'b0;
    chk("after_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("after_req_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_funct3 = '0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_rd = '0;     bus.dmem_rdata = '0; bus.dmem_resp = 1'b0;
    bus.resp_ready = 1'b0;

    tbl.push_back(mk(7'h23, 3'd2, 32'h1000, 32'hDEADBEEF, 32'h0, 5'd7, 0, 0, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 5'd0, 2'd0));
    tbl.push_back(mk(7'h03, 3'd0, 32'h2003, 32'h0, 32'h80FFFF7F, 5'd5, 0, 0, 4'h8, 4'h0, 32'h0, 32'hFFFFFF80, 5'd5, 2'd0));
    tbl.push_back(mk(7'h03, 3'd4, 32'h2003, 32'h0, 32'h80FFFF7F, 5'd5, 1, 0, 4'h8, 4'h0, 32'h0, 32'h00000080, 5'd5, 2'd0));
    tbl.push_back(mk(7'h23, 3'd1, 32'h3002, 32'h0000ABCD, 32'h0, 5'd1, 0, 0, 4'h0, 4'hC, 32'hABCD0000, 32'h0, 5'd0, 2'd0));
    tbl.push_back(mk(7'h03, 3'd5, 32'h3002, 32'h0, 32'hABCD1234, 5'd2, 0, 1, 4'hC, 4'h0, 32'h0, 32'h0000ABCD, 5'd2, 2'd0));
    tbl.push_back(mk(7'h03, 3'd2, 32'h4001, 32'h0, 32'h0, 5'd3, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 5'd0, 2'd1));
    tbl.push_back(mk(7'h03, 3'd6, 32'h5000, 32'h0, 32'h0, 5'd4, 0, 3, 4'h0, 4'h0, 32'h0, 32'h0, 5'd0, 2'd2));
    tbl.push_back(mk(7'h33, 3'd0, 32'h5004, 32'h0, 32'h0, 5'd4, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 5'd0, 2'd2));
    tbl.push_back(mk(7'h03, 3'd1, 32'h6002, 32'h0, 32'h80010000, 5'd6, 2, 1, 4'hC, 4'h0, 32'h0, 32'hFFFF8001, 5'd6, 2'd0));
    tbl.push_back(mk(7'h23, 3'd0, 32'h7001, 32'h12345678, 32'h0, 5'd0, 0, 0, 4'h0, 4'h2, 32'h34567800, 32'h0, 5'd0, 2'd0));
    tbl.push_back(mk(7'h23, 3'd3, 32'h7000, 32'h1, 32'h0, 5'd0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 5'd0, 2'd2));
    tbl.push_back(mk(7'h23, 3'd1, 32'h7001, 32'h1, 32'h0, 5'd0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 5'd0, 2'd1));
    tbl.push_back(mk(7'h23, 3'd5, 32'h7003, 32'h1, 32'h0, 5'd0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 5'd0, 2'd2));
    tbl.push_back(mk(7'h03, 3'd2, 32'h8000, 32'h0, 32'hCAFEF00D, 5'd31, 1, 0, 4'hF, 4'h0, 32'h0, 32'hCAFEF00D, 5'd31, 2'd0));
`ifdef LSU_TIMEOUT_EN
    tbl.push_back(mk(7'h03, 3'd2, 32'h9000, 32'h0, 32'h0, 5'd9, 99, 0, 4'hF, 4'h0, 32'h0, 32'h0, 5'd0, 2'd3));
    tbl.push_back(mk(7'h03, 3'd2, 32'h9000, 32'h0, 32'h11223344, 5'd9, 3, 0, 4'hF, 4'h0, 32'h0, 32'h11223344, 5'd9, 2'd0));
`endif

    step();
    step();
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_dmem", bus.dmem_addr | bus.dmem_wdata | {24'd0, bus.dmem_rmask, bus.dmem_wmask}, 32'd0);
    chk("rst_resp", bus.resp_data | {25'd0, bus.resp_rd, bus.resp_err}, 32'd0);
    rst = 1'b0;
    step();

    foreach (tbl[i]) run(tbl[i]);

    // Reset while a load is waiting; the late memory response must be dropped.
    bus.req_valid = 1'b1; bus.req_opcode = 7'h03; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h100; bus.req_rd = 5'd3;
    step();
    bus.req_valid = 1'b0;
    chk("rstw_rmask_before", {28'd0, bus.dmem_rmask}, 32'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rstw_rmask", {28'd0, bus.dmem_rmask}, 32'd0);
    chk("rstw_addr", bus.dmem_addr, 32'd0);
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h1234;
    step();
    bus.dmem_resp = 1'b0;
    chk("rstw_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rstw_resp_data", bus.resp_data, 32'd0);
    chk("rstw_req_ready2", {31'd0, bus.req_ready}, 32'd1);
    step();
    chk("rstw_resp_valid2", {31'd0, bus.resp_valid}, 32'd0);

    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      int sel;
      sel = int'($urandom_range(0, 9));
      op  = (sel < 4) ? 7'h03 : (sel < 8) ? 7'h23 : (sel == 8) ? 7'h13 : 7'h33;
      run(model(op, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)), int'($urandom_range(0, 6)), int'($urandom_range(0, 2))));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
